cordic_iter: RTL and testbench



---
 rtl/cordic_pkg.sv | 70 +++++++
 rtl/cordic_atan_rom.sv | 27 ++
 rtl/cordic_iter.sv | 180 ++++++++++++++++++
 tb/tb_cordic_iter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and elaboration-time helpers for the iterative CORDIC core.
// The optional vectoring mode is enabled with CORDIC_VECTOR_EN (see cordic_iter).
package cordic_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cordic_iw(input int data_w, input int guard);
    return data_w + guard;
  endfunction

  function automatic int cordic_cnt_w(input int iter);
    return $clog2(iter + 1);
  endfunction

  // atan(2^-i) in binary angle units where 2^32 is a full turn.
  function automatic logic [63:0] atan_b32(input int i);
    case (i)
      0:       return 64'h2000_0000;
      1:       return 64'h12E4_051E;
      2:       return 64'h09FB_385B;
      3:       return 64'h0511_11D4;
      4:       return 64'h028B_0D43;
      5:       return 64'h0145_D7E1;
      6:       return 64'h00A2_F61E;
      7:       return 64'h0051_7C55;
      8:       return 64'h0028_BE53;
      9:       return 64'h0014_5F2F;
      10:      return 64'h000A_2F98;
      11:      return 64'h0005_17CC;
      12:      return 64'h0002_8BE6;
      13:      return 64'h0001_45F3;
      14:      return 64'h0000_A2FA;
      15:      return 64'h0000_517D;
      default: return (64'd683565276 + (64'd1 << (i - 1))) >> i;
    endcase
  endfunction

  function automatic int atan_angle(input int i, input int angle_w);
    logic [63:0] v;
    int          sh;
    v  = atan_b32(i);
    sh = 32 - angle_w;
    if (sh > 0) v = (v + (64'd1 << (sh - 1))) >> sh;
    else        v = v;
    return int'(v);
  endfunction

  // round(K * 2^(iw-2)); K^2 is built exactly at 2^62 scale, then square-rooted bitwise.
  function automatic int cordic_k_init(input int iter, input int iw);
    logic [63:0] kk, root, trial;
    int          sh;
    kk = 64'h4000_0000_0000_0000;
    for (int i = 0; i < iter; i++) begin
      if (2 * i < 62) kk = kk - kk / ((64'd1 << (2 * i)) + 64'd1);
      else            kk = kk;
    end
    root = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      trial = root | (64'd1 << b);
      if (trial * trial <= kk) root = trial;
      else                     root = root;
    end
    sh = 31 - (iw - 2);
    return int'((root + (64'd1 << (sh - 1))) >> sh);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: index -> round(2^(ANGLE_W-1)*atan(2^-i)/pi).
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int ITER    = 14,
  parameter int CNT_W   = 4
) (
  input  logic [CNT_W-1:0]   idx,
  output logic [ANGLE_W-1:0] angle
);

  logic [ANGLE_W-1:0] rom_s [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_rom
    assign rom_s[g] = ANGLE_W'(atan_angle(g, ANGLE_W));
  end

  // select the table entry; out-of-range indices read as zero
  always_comb begin
    angle = '0;
    for (int k = 0; k < ITER; k++) begin
      angle = (idx == CNT_W'(k)) ? rom_s[k] : angle;
    end
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock, valid/ready on both sides.
// Defining CORDIC_VECTOR_EN adds a vectoring mode (in_mode/in_x/in_y ports).
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 16,
  parameter int ITER    = 14,
  parameter int GUARD   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
`ifdef CORDIC_VECTOR_EN
  input  logic               in_mode,
  input  logic [DATA_W-1:0]  in_x,
  input  logic [DATA_W-1:0]  in_y,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sin,
  output logic [DATA_W-1:0]  out_cos,
  output logic [ANGLE_W-1:0] out_angle
);

  localparam int IW    = cordic_iw(DATA_W, GUARD);
  localparam int CNT_W = cordic_cnt_w(ITER);
  localparam logic signed [IW-1:0] X_INIT = IW'(cordic_k_init(ITER, IW));
  localparam logic signed [IW+1:0] SAT_HI = (IW+2)'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic signed [IW+1:0] SAT_LO = -SAT_HI;
  localparam logic signed [IW+1:0] RND    = (IW+2)'((64'd1 << GUARD) >> 1);

  state_t                    state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [IW-1:0]      x_r, y_r;
  logic [ANGLE_W-1:0]        z_r;
  logic                      neg_r;
  logic                      out_valid_r;
  logic [DATA_W-1:0]         out_sin_r, out_cos_r;
  logic [ANGLE_W-1:0]        out_angle_r;
`ifdef CORDIC_VECTOR_EN
  logic                      mode_r;
`endif

  logic                      accept_s, d_s, neg_init_s;
  logic signed [IW-1:0]      x_sh_s, y_sh_s, x_nxt_s, y_nxt_s, x_init_s, y_init_s;
  logic [ANGLE_W-1:0]        z_nxt_s, z_init_s, atan_s;

  // Fold sign, drop guard bits with round-half-up, clamp to a symmetric range.
  function automatic logic [DATA_W-1:0] round_sat(input logic signed [IW-1:0] v, input logic neg);
    logic signed [IW+1:0] e;
    e = (IW+2)'(v);
    if (neg) e = -e;
    else     e = e;
    e = (e + RND) >>> GUARD;
    if (e > SAT_HI)      return SAT_HI[DATA_W-1:0];
    else if (e < SAT_LO) return SAT_LO[DATA_W-1:0];
    else                 return e[DATA_W-1:0];
  endfunction

  cordic_atan_rom #(.ANGLE_W(ANGLE_W), .ITER(ITER), .CNT_W(CNT_W)) u_rom (
    .idx   (cnt_r),
    .angle (atan_s)
  );

  assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_sin   = out_sin_r;
  assign out_cos   = out_cos_r;
  assign out_angle = out_angle_r;

  // operand load values: quadrant fold for rotation, half-plane fold for vectoring
  always_comb begin
    neg_init_s = 1'b0;
    x_init_s   = X_INIT;
    y_init_s   = '0;
    z_init_s   = '0;
`ifdef CORDIC_VECTOR_EN
    if (in_mode) begin
      if (in_x[DATA_W-1]) begin
        x_init_s = -(IW'($signed(in_x)) <<< GUARD);
        y_init_s = -(IW'($signed(in_y)) <<< GUARD);
        z_init_s = {1'b1, {(ANGLE_W-1){1'b0}}};
      end else begin
        x_init_s = IW'($signed(in_x)) <<< GUARD;
        y_init_s = IW'($signed(in_y)) <<< GUARD;
      end
    end else begin
      neg_init_s = in_angle[ANGLE_W-1] ^ in_angle[ANGLE_W-2];
      z_init_s   = {in_angle[ANGLE_W-1] ^ neg_init_s, in_angle[ANGLE_W-2:0]};
    end
`else
    neg_init_s = in_angle[ANGLE_W-1] ^ in_angle[ANGLE_W-2];
    z_init_s   = {in_angle[ANGLE_W-1] ^ neg_init_s, in_angle[ANGLE_W-2:0]};
`endif
  end

  // one micro-rotation; d selects the direction that drives z (or y) toward zero
  always_comb begin
    x_sh_s = x_r >>> cnt_r;
    y_sh_s = y_r >>> cnt_r;
`ifdef CORDIC_VECTOR_EN
    if (mode_r) d_s = y_r[IW-1];
    else        d_s = ~z_r[ANGLE_W-1];
`else
    d_s = ~z_r[ANGLE_W-1];
`endif
    if (d_s) begin
      x_nxt_s = x_r - y_sh_s;
      y_nxt_s = y_r + x_sh_s;
      z_nxt_s = z_r - atan_s;
    end else begin
      x_nxt_s = x_r + y_sh_s;
      y_nxt_s = y_r - x_sh_s;
      z_nxt_s = z_r + atan_s;
    end
  end

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      neg_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_sin_r   <= '0;
      out_cos_r   <= '0;
      out_angle_r <= '0;
`ifdef CORDIC_VECTOR_EN
      mode_r      <= 1'b0;
`endif
    end else if (accept_s) begin
      state_r     <= ST_RUN;
      cnt_r       <= '0;
      x_r         <= x_init_s;
      y_r         <= y_init_s;
      z_r         <= z_init_s;
      neg_r       <= neg_init_s;
      out_valid_r <= 1'b0;
`ifdef CORDIC_VECTOR_EN
      mode_r      <= in_mode;
`endif
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_RUN: begin
          if (cnt_r == CNT_W'(ITER)) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            out_cos_r   <= round_sat(x_r, neg_r);
            out_sin_r   <= round_sat(y_r, neg_r);
            out_angle_r <= z_r;
          end else begin
            x_r   <= x_nxt_s;
            y_r   <= y_nxt_s;
            z_r   <= z_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed scoreboard bench for cordic_iter (DATA_W=ANGLE_W=16, ITER=14); expectations from a real-valued sin/cos model.
module tb_cordic_iter;

  localparam int  DW  = 16;
  localparam int  AW  = 16;
  localparam int  LAT = 15;
  localparam real PI  = 3.14159265358979;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [AW-1:0] in_angle, out_angle;
  logic [DW-1:0] out_sin, out_cos;
`ifdef CORDIC_VECTOR_EN
  logic          in_mode;
  logic [DW-1:0] in_x, in_y;
`endif

  typedef struct {
    string tag;
    int    s;
    int    c;
    int    ang;
    bit    chk_ang;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  cordic_iter #(.DATA_W(DW), .ANGLE_W(AW), .ITER(14), .GUARD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
`ifdef CORDIC_VECTOR_EN
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .out_cos   (out_cos),
    .out_angle (out_angle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    logic ok;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int model(input logic [AW-1:0] a, input bit want_sin);
    real r;
    r = real'($signed(a)) * PI / 32768.0;
    if (want_sin) return int'(16384.0 * $sin(r));
    else          return int'(16384.0 * $cos(r));
  endfunction

  task automatic push_rot(input string tag, input logic [AW-1:0] a);
    exp_t e;
    e.tag = tag; e.s = model(a, 1'b1); e.c = model(a, 1'b0); e.ang = 0; e.chk_ang = 1'b0;
    sb.push_back(e);
  endtask

  task automatic send_rot(input string tag, input logic [AW-1:0] a);
    int n;
    n = 0;
`ifdef CORDIC_VECTOR_EN
    in_mode = 1'b0;
`endif
    in_angle = a;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check({"ready_", tag}, int'(in_ready), 1, 0);
    push_rot(tag, a);
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int exp_lat);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check("out_valid_seen", int'(out_valid), 1, 0);
    check("sb_depth", sb.size(), 1, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_latency"}, cyc - acc_cyc, exp_lat, 0);
      check({e.tag, "_sin"}, int'($signed(out_sin)), e.s, 3);
      check({e.tag, "_cos"}, int'($signed(out_cos)), e.c, 3);
      if (e.chk_ang) check({e.tag, "_angle"}, int'($signed(out_angle)), e.ang, 3);
    end
  endtask

  task automatic run_rot(input string tag, input logic [AW-1:0] a);
    send_rot(tag, a);
    get_result(LAT);
    step();
  endtask

  initial begin
    int seen;
    exp_t ve;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_angle = '0;
`ifdef CORDIC_VECTOR_EN
    in_mode = 1'b0; in_x = '0; in_y = '0;
`endif
    step(); step(); step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_sin", int'(out_sin), 0, 0);
    check("rst_cos", int'(out_cos), 0, 0);
    check("rst_angle", int'(out_angle), 0, 0);

    run_rot("th0", 16'h0000);
    run_rot("th45", 16'h2000);
    run_rot("th90", 16'h4000);
    run_rot("thm180", 16'h8000);
    run_rot("th135", 16'h6000);
    run_rot("thm45", 16'hE000);
    run_rot("thm135", 16'hA000);

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send_rot("bp45", 16'h2000);
    get_result(LAT);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_valid", int'(out_valid), 1, 0);
      check("bp_hold_in_ready", int'(in_ready), 0, 0);
      check("bp_hold_sin", int'($signed(out_sin)), model(16'h2000, 1'b1), 3);
      check("bp_hold_cos", int'($signed(out_cos)), model(16'h2000, 1'b0), 3);
    end
    in_angle = 16'h6000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("handoff_in_ready", int'(in_ready), 1, 0);
    push_rot("handoff135", 16'h6000);
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    check("handoff_valid_clear", int'(out_valid), 0, 0);
    get_result(LAT);
    step();

    // reset in the middle of an operation discards it
    in_angle = 16'h2000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1, 0);
    check("midrst_out_valid", int'(out_valid), 0, 0);
    check("midrst_sin", int'(out_sin), 0, 0);
    check("midrst_cos", int'(out_cos), 0, 0);
    seen = 0;
    repeat (25) begin
      step();
      if (out_valid) seen = 1;
    end
    check("midrst_no_valid", seen, 0, 0);
    run_rot("recover_m90", 16'hC000);

`ifdef CORDIC_VECTOR_EN
    in_mode = 1'b1; in_x = 16'd8192; in_y = 16'd8192; in_valid = 1'b1;
    ve.tag = "vec45"; ve.s = 0; ve.c = 19079; ve.ang = 8192; ve.chk_ang = 1'b1;
    sb.push_back(ve);
    step();
    acc_cyc = cyc;
    in_valid = 1'b0; in_mode = 1'b0;
    get_result(LAT);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
